// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - NES $4016 joypad port: onboard|USB shift register or external pad passthrough; JOYPAD_DEBOUNCE_EN adds button debouncing
module nes_joypad_port #(
  parameter int DEBOUNCE_TICKS   = 21477,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       nes_strobe,
  input  logic       nes_clock,
  input  logic       use_external,
  input  logic [7:0] btn_raw,
  input  logic [7:0] usb_buttons,
  input  logic       ext_data,
  output logic       ext_strobe,
  output logic       ext_clock,
  output logic       joy_bit,
  output logic [7:0] buttons_state
);

  // A zero sample period or sample count has no meaning; stop at elaboration.
  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_SAMPLES < 1) begin : g_bad_params
    $error("nes_joypad_port: DEBOUNCE_TICKS and DEBOUNCE_SAMPLES must be >= 1");
  end

  logic [7:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic       ext_s1_q, ext_s1_d, ext_s2_q, ext_s2_d;
  logic       use_s1_q, use_s1_d, use_s2_q, use_s2_d;
  logic [7:0] sr_q, sr_d;
  logic       ext_bit_q, ext_bit_d;
  logic       ext_strobe_q, ext_strobe_d;
  logic       ext_clock_q, ext_clock_d;
  logic [7:0] buttons_state_q, buttons_state_d;
  logic [7:0] debounced_btn;
  logic [7:0] merged;
  logic       shift_pulse;

`ifdef JOYPAD_DEBOUNCE_EN
  localparam int TICK_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int SAMP_W = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_TICKS - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(DEBOUNCE_SAMPLES - 1);

  logic [TICK_W-1:0]            tick_cnt_q, tick_cnt_d;
  logic [7:0][SAMP_W-1:0]       samp_cnt_q, samp_cnt_d;
  logic [7:0]                   level_q, level_d;
  logic                         tick;

  // Shared sample tick; each bit counts consecutive differing samples and flips
  // its accepted level on the last one, so a counter never holds its terminal value.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = samp_cnt_q;
    level_d    = level_q;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (btn_s2_q[i] != level_q[i]) begin
          if (samp_cnt_q[i] == SAMP_LAST) begin
            level_d[i]    = ~level_q[i];
            samp_cnt_d[i] = '0;
          end else begin
            samp_cnt_d[i] = samp_cnt_q[i] + SAMP_W'(1);
          end
        end else begin
          samp_cnt_d[i] = '0;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      level_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      level_q    <= level_d;
    end
  end

  assign debounced_btn = level_q;
`else
  assign debounced_btn = btn_s2_q;
`endif

  // Synchronizers, shift register and forwarded pad signals.
  always_comb begin
    btn_s1_d = btn_raw;
    btn_s2_d = btn_s1_q;
    ext_s1_d = ext_data;
    ext_s2_d = ext_s1_q;
    use_s1_d = use_external;
    use_s2_d = use_s1_q;

    merged      = debounced_btn | usb_buttons;
    // ext_clock_q doubles as the registered previous nes_clock.
    shift_pulse = ext_clock_q & ~nes_clock;

    // In external mode the register is frozen; the next strobe refreshes it.
    sr_d = sr_q;
    if (!use_s2_q) begin
      if (nes_strobe) begin
        sr_d = merged;
      end else if (shift_pulse) begin
        sr_d = {1'b1, sr_q[7:1]};
      end
    end

    ext_bit_d       = ~ext_s2_q;
    ext_strobe_d    = nes_strobe;
    ext_clock_d     = nes_clock;
    buttons_state_d = merged;
  end

  // Main state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_s1_q        <= '0;
      btn_s2_q        <= '0;
      ext_s1_q        <= 1'b1;
      ext_s2_q        <= 1'b1;
      use_s1_q        <= 1'b0;
      use_s2_q        <= 1'b0;
      sr_q            <= 8'hFF;
      ext_bit_q       <= 1'b1;
      ext_strobe_q    <= 1'b0;
      ext_clock_q     <= 1'b0;
      buttons_state_q <= '0;
    end else begin
      btn_s1_q        <= btn_s1_d;
      btn_s2_q        <= btn_s2_d;
      ext_s1_q        <= ext_s1_d;
      ext_s2_q        <= ext_s2_d;
      use_s1_q        <= use_s1_d;
      use_s2_q        <= use_s2_d;
      sr_q            <= sr_d;
      ext_bit_q       <= ext_bit_d;
      ext_strobe_q    <= ext_strobe_d;
      ext_clock_q     <= ext_clock_d;
      buttons_state_q <= buttons_state_d;
    end
  end

  assign ext_strobe    = ext_strobe_q;
  assign ext_clock     = ext_clock_q;
  assign joy_bit       = use_s2_q ? ext_bit_q : sr_q[0];
  assign buttons_state = buttons_state_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - self-checking bench for nes_joypad_port against a read-index reference model
module tb_nes_joypad_port;
`ifdef JOYPAD_DEBOUNCE_EN
  localparam int TICKS = 4;
  localparam bit DEB   = 1'b1;
`else
  localparam int TICKS = 21477;
  localparam bit DEB   = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, nes_strobe, nes_clock, use_external, ext_data;
  logic [7:0] btn_raw, usb_buttons;
  logic       ext_strobe, ext_clock, joy_bit;
  logic [7:0] buttons_state;

  nes_joypad_port #(.DEBOUNCE_TICKS(TICKS), .DEBOUNCE_SAMPLES(3)) dut (
    .clock(clock), .reset_n(reset_n), .nes_strobe(nes_strobe), .nes_clock(nes_clock),
    .use_external(use_external), .btn_raw(btn_raw), .usb_buttons(usb_buttons),
    .ext_data(ext_data), .ext_strobe(ext_strobe), .ext_clock(ext_clock),
    .joy_bit(joy_bit), .buttons_state(buttons_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a latched report plus the number of reads taken from it.
  logic [7:0] m_latched, m_bs, m_btn_d1, m_btn_d2;
  int         m_idx;
  logic       m_use_d1, m_use_d2, m_ext_d1, m_ext_d2, m_ext_bit;
  logic       m_prev_clk, m_estb, m_eclk;
  bit         chk_bs = 1'b1;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_joy();
    if (m_use_d2) return m_ext_bit;
    if (m_idx < 8) return m_latched[m_idx];
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [7:0] merged;
    logic       fall;
    if (!reset_n) begin
      m_btn_d1 = '0; m_btn_d2 = '0;
      m_use_d1 = 1'b0; m_use_d2 = 1'b0;
      m_ext_d1 = 1'b1; m_ext_d2 = 1'b1; m_ext_bit = 1'b1;
      m_latched = 8'hFF; m_idx = 0;
      m_prev_clk = 1'b0; m_estb = 1'b0; m_eclk = 1'b0; m_bs = '0;
    end else begin
      merged = (DEB ? 8'h00 : m_btn_d2) | usb_buttons;
      fall   = m_prev_clk && !nes_clock;
      if (!m_use_d2) begin
        if (nes_strobe) begin
          m_latched = merged;
          m_idx     = 0;
        end else if (fall && m_idx < 8) begin
          m_idx++;
        end
      end
      m_bs      = merged;
      m_ext_bit = ~m_ext_d2;
      m_use_d2  = m_use_d1; m_use_d1 = use_external;
      m_ext_d2  = m_ext_d1; m_ext_d1 = ext_data;
      m_btn_d2  = m_btn_d1; m_btn_d1 = btn_raw;
      m_prev_clk = nes_clock; m_estb = nes_strobe; m_eclk = nes_clock;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_val("joy_bit", {7'd0, joy_bit}, {7'd0, exp_joy()});
    check_val("ext_strobe", {7'd0, ext_strobe}, {7'd0, m_estb});
    check_val("ext_clock", {7'd0, ext_clock}, {7'd0, m_eclk});
    if (chk_bs) check_val("buttons_state", buttons_state, m_bs);
  endtask

  task automatic fall_clk();
    nes_clock = 1'b1; step();
    nes_clock = 1'b0; step();
  endtask

  task automatic strobe_pulse();
    nes_strobe = 1'b1; step();
    nes_strobe = 1'b0; step();
  endtask

  initial begin
    bit   seq34 [11] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic prev_ext;
    bit   seen;

    reset_n = 1'b0; nes_strobe = 1'b0; nes_clock = 1'b0; use_external = 1'b0;
    ext_data = 1'b1; btn_raw = '0; usb_buttons = '0;
    step(); step();
    check_val("rst_joy", {7'd0, joy_bit}, 8'h01);
    check_val("rst_estb", {7'd0, ext_strobe}, 8'h00);
    check_val("rst_eclk", {7'd0, ext_clock}, 8'h00);
    check_val("rst_bs", buttons_state, 8'h00);
    reset_n = 1'b1;
    repeat (3) step();

    // Read sequence of a report with A and R pressed.
    usb_buttons = 8'h81;
    repeat (3) step();
    strobe_pulse();
    check_val("seq_0", {7'd0, joy_bit}, {7'd0, seq34[0]});
    for (int i = 1; i < 11; i++) begin
      fall_clk();
      check_val($sformatf("seq_%0d", i), {7'd0, joy_bit}, {7'd0, seq34[i]});
    end

    // Falls during strobe do not advance; first fall afterwards presents B.
    usb_buttons = 8'h02;
    nes_strobe = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      fall_clk();
      check_val("strobe_hold", {7'd0, joy_bit}, 8'h00);
    end
    nes_strobe = 1'b0; step();
    check_val("strobe_rel_a", {7'd0, joy_bit}, 8'h00);
    fall_clk();
    check_val("strobe_rel_b", {7'd0, joy_bit}, 8'h01);

    // Reset mid-read.
    usb_buttons = 8'h81;
    strobe_pulse();
    repeat (3) fall_clk();
    check_val("mid_read", {7'd0, joy_bit}, 8'h00);
    reset_n = 1'b0; step();
    check_val("mid_rst_joy", {7'd0, joy_bit}, 8'h01);
    reset_n = 1'b1; step();
    fall_clk();
    check_val("post_rst_ff", {7'd0, joy_bit}, 8'h01);
    strobe_pulse();
    check_val("post_rst_a", {7'd0, joy_bit}, 8'h01);
    fall_clk();
    check_val("post_rst_b", {7'd0, joy_bit}, 8'h00);

    // External pad passthrough, inverted, three cycles from the pin.
    use_external = 1'b1; ext_data = 1'b1;
    repeat (4) step();
    prev_ext = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ext_data = i[0]; nes_strobe = ~i[0]; nes_clock = i[1];
      step();
      check_val("ext_estb", {7'd0, ext_strobe}, {7'd0, ~i[0]});
      nes_strobe = 1'b0;
      step();
      check_val("ext_lat2", {7'd0, joy_bit}, {7'd0, ~prev_ext});
      step();
      check_val("ext_lat3", {7'd0, joy_bit}, {7'd0, ~ext_data});
      prev_ext = ext_data;
    end
    use_external = 1'b0; nes_clock = 1'b0;
    repeat (3) step();

`ifdef JOYPAD_DEBOUNCE_EN
    chk_bs = 1'b0; usb_buttons = '0; btn_raw = '0;
    repeat (4) step();
    btn_raw = 8'h01;
    repeat (5) step();
    btn_raw = 8'h00;
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("deb_glitch", {7'd0, buttons_state[0]}, 8'h00);
    end
    btn_raw = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step();
      seen = buttons_state[0];
    end
    check_val("deb_rise", {7'd0, seen}, 8'h01);
    repeat (5) step();
    btn_raw = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = !buttons_state[0];
    end
    check_val("deb_fall", {7'd0, seen}, 8'h01);
    chk_bs = 1'b1;
`else
    seen = 1'b0;
    usb_buttons = '0; btn_raw = '0;
    repeat (3) step();
    btn_raw = 8'h10;
    step(); check_val("nodeb_c1", {7'd0, buttons_state[4]}, 8'h00);
    step(); check_val("nodeb_c2", {7'd0, buttons_state[4]}, 8'h00);
    step(); check_val("nodeb_c3", {7'd0, buttons_state[4]}, 8'h01);
    btn_raw = '0;
    repeat (3) step();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      nes_strobe = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) nes_clock = ~nes_clock;
      if ($urandom_range(0, 99) == 0) use_external = ~use_external;
      ext_data = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) usb_buttons = 8'($urandom);
      if (!DEB && $urandom_range(0, 24) == 0) btn_raw = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 21477, is the debounce sample period in clock cycles (1 ms at 21.477 MHz).
REQ-002 Parameter DEBOUNCE_SAMPLES, default 3, is the number of consecutive equal samples needed to accept a new onboard button level.
REQ-003 clock  in  1  NES system clock; single clock domain for the block.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 nes_strobe  in  1  $4016 strobe from NES core, active-high.
REQ-006 nes_clock  in  1  joypad read clock from NES core; a read completes on its falling edge.
REQ-007 use_external  in  1  1 selects the external NES pad, 0 selects onboard OR USB buttons; asynchronous.
REQ-008 btn_raw  in  8  onboard buttons {R,L,D,U,Start,Select,B,A}, active-high, asynchronous.
REQ-009 usb_buttons  in  8  USB pad state in the same bit order, active-high, already held stable in this domain.
REQ-010 ext_data  in  1  external pad serial data, active-low, asynchronous.
REQ-011 ext_strobe  out  1  strobe forwarded to external pad.
REQ-012 ext_clock  out  1  clock forwarded to external pad.
REQ-013 joy_bit  out  1  serial bit D0 returned to NES core, active-high.
REQ-014 buttons_state  out  8  current merged onboard|USB state, for LEDs.

Function
REQ-015 btn_raw, ext_data and use_external each pass through a 2-flop synchronizer before any use.
REQ-016 ext_strobe and ext_clock are registered copies of nes_strobe and nes_clock, with 1 cycle of latency.
REQ-017 The falling edge of nes_clock is detected as prev=1 and cur=0, using a registered previous value; it yields a one-cycle shift pulse.
REQ-018 Internal mode: while nes_strobe=1, shift register sr[7:0] reloads every cycle with debounced_btn | usb_buttons.
REQ-019 Internal mode: on a shift pulse with nes_strobe=0, sr <= {1'b1, sr[7:1]}, so after 8 shifts joy_bit reads 1 indefinitely.
REQ-020 If strobe and a shift pulse occur in the same cycle, reload wins.
REQ-021 joy_bit = sr[0] in internal mode.
REQ-022 joy_bit = NOT synchronized ext_data in external mode, registered, 3 cycles of total latency from the pin.
REQ-023 A change of synchronized use_external takes effect on the next cycle; sr is unaffected and the next strobe reloads it.
REQ-024 buttons_state = debounced_btn | usb_buttons, registered.
REQ-025 Debounce uses a shared tick counter that counts 0..DEBOUNCE_TICKS-1, wraps to 0, and emits a tick on the wrap.
REQ-026 On each tick, per bit: if the sample differs from the accepted level, increment that bit's counter, else clear it.
REQ-027 When a bit's counter reaches DEBOUNCE_SAMPLES, the accepted level toggles and the counter clears.
REQ-028 Counter widths are the minimum $clog2 sizes; no counter saturates or overflows past its terminal value.

Reset
REQ-029 On reset_n=0 at a clock edge: sr=8'hFF, joy_bit=1, ext_strobe=0, ext_clock=0, buttons_state=0.
REQ-030 On reset_n=0 at a clock edge, all debounce counters, accepted levels and the tick counter reset to 0, and all synchronizer flops reset to 0 (ext_data flops to 1).
REQ-031 Reset asserted mid-read aborts the sequence; the first strobe after release reloads normally.

Configuration
REQ-032 Macro JOYPAD_DEBOUNCE_EN: when defined, onboard buttons go through the debouncer per REQ-025..REQ-027.
REQ-033 When JOYPAD_DEBOUNCE_EN is undefined, the debouncer logic is absent and debounced_btn equals the synchronized btn_raw, with 2 cycles of latency; DEBOUNCE_* parameters are then ignored.

Verification
REQ-034 Internal mode, btn_raw=0, usb_buttons=8'h81: pulse strobe, then 10 nes_clock falls -> joy_bit sequence 1,0,0,0,0,0,0,1,1,1,1.
REQ-035 Strobe held high with 3 nes_clock falls during it -> joy_bit stays at bit A; the first fall after strobe drops presents bit B.
REQ-036 Debounce enabled, DEBOUNCE_TICKS=4: btn_raw[0] glitches high for 5 cycles -> buttons_state[0] stays 0; held high for 20 cycles -> becomes 1 within 3 ticks plus 3 cycles.
REQ-037 External mode, ext_data toggling: ext_strobe and ext_clock follow their inputs at +1 cycle, and joy_bit = NOT ext_data at +3 cycles.
REQ-038 reset_n pulled low after 3 shifts -> joy_bit=1 and sr=FF; after release, a strobe reloads the correct merged value.
REQ-039 Build without JOYPAD_DEBOUNCE_EN, btn_raw[4] rising -> buttons_state[4]=1 exactly 3 cycles later.
